// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
//
// Purpose: constants shared by the UART receiver and transmitter.
//   - default CLKS_PER_BIT, frame shape (start=0, stop=1, 8 data bits)
//   - receiver FSM state encoding
//   - helper computing the start-bit half-period counter load
// Ports: none (package).
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 1;
    localparam int UART_DATA_BITS            = 8;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE      = 3'd0;
    localparam uart_state_t ST_START     = 3'd1;
    localparam uart_state_t ST_DATA      = 3'd2;
    localparam uart_state_t ST_STOP      = 3'd3;
    localparam uart_state_t ST_WAIT_IDLE = 3'd4;

    // Counter load on a falling edge so the start bit is sampled near its middle.
    function automatic int uart_half(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
//
// Purpose: bring an asynchronous 1-bit signal into the clk domain.
// Ports:
//   clk    in   1  clock
//   rst_n  in   1  asynchronous active-low reset, both flops load RESET_VAL
//   d      in   1  asynchronous input
//   q      out  1  synchronized output, 2 cycles of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling
//
// Purpose: receive start + 8 data bits (LSB first) + stop, no parity.
// Ports:
//   clk          in   1  clock, all state updates on the rising edge
//   rst_n        in   1  asynchronous active-low reset
//   rxd          in   1  serial line, idle high, asynchronous to clk
//   data         out  8  last correctly received byte
//   received     out  1  one-cycle pulse, data has just been updated
//   frame_error  out  1  one-cycle pulse, stop bit sampled low
//   busy         out  1  high whenever the FSM is not in IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 received,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  HALF     = CNT_W'(uart_half(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_IDX = 3'(DATA_BITS - 1);

    logic                 w_rxd_s;
    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_received;
    logic                 r_frame_error;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (w_rxd_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_received    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            // Pulses are cleared every cycle so they can never exceed one cycle.
            r_received    <= 1'b0;
            r_frame_error <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rxd_s == UART_START_BIT) begin
                        r_state <= ST_START;
                        r_cnt   <= HALF;
                    end
                end

                ST_START: begin
                    if (r_cnt == '0) begin
                        if (w_rxd_s != UART_START_BIT) begin
                            // Line went back high before mid-start: glitch, not a frame.
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                            r_cnt     <= RELOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift[r_bit_idx] <= w_rxd_s;
                        r_cnt              <= RELOAD;
                        if (r_bit_idx == LAST_IDX) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (r_cnt == '0) begin
                        if (w_rxd_s == UART_STOP_BIT) begin
                            // Whole byte is committed at once, so data never shows partial frames.
                            r_data     <= r_shift;
                            r_received <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= ST_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_WAIT_IDLE: begin
                    // A held-low line (break) parks here until it returns high.
                    if (w_rxd_s == UART_STOP_BIT) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data        = r_data;
    assign received    = r_received;
    assign frame_error = r_frame_error;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at CLKS_PER_BIT 1 and 4
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd1, rxd4;
    logic [7:0] data1, data4;
    logic       rx1, rx4, fe1, fe4, busy1, busy4;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(1)) u_rx1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd1),
        .data        (data1),
        .received    (rx1),
        .frame_error (fe1),
        .busy        (busy1)
    );

    uart_rx #(.CLKS_PER_BIT(4)) u_rx4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd4),
        .data        (data4),
        .received    (rx4),
        .frame_error (fe4),
        .busy        (busy4)
    );

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] byte_v;
        logic       stop;
        logic       exp_err;
    } vec_t;

    exp_t       q1[$];
    exp_t       q4[$];
    exp_t       e1, e4;
    vec_t       vecs[7];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         pulses1 = 0, pulses4 = 0;
    int         last_pulse4 = 0;
    int         frame_t0 = 0;
    logic       prev_p1 = 1'b0, prev_p4 = 1'b0;
    logic [7:0] prev_d1 = 8'h00, prev_d4 = 8'h00;
    logic [7:0] good4 = 8'h00;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx1 || fe1) begin
            pulses1++;
            check("rx1_exclusive", 32'(rx1 & fe1), 32'd0);
            check("rx1_width", 32'(prev_p1), 32'd0);
            if (q1.size() == 0) begin
                check("rx1_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("rx1_kind", 32'(fe1), 32'(e1.is_err));
                check("rx1_data", 32'(data1), 32'(e1.data));
            end
        end
        if (rst_n && data1 !== prev_d1) check("data1_changes_only_on_rx", 32'(rx1), 32'd1);
        prev_p1 = rx1 | fe1;
        prev_d1 = data1;
    end

    always @(negedge clk) begin
        if (rx4 || fe4) begin
            pulses4++;
            last_pulse4 = cyc;
            check("rx4_exclusive", 32'(rx4 & fe4), 32'd0);
            check("rx4_width", 32'(prev_p4), 32'd0);
            if (q4.size() == 0) begin
                check("rx4_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("rx4_kind", 32'(fe4), 32'(e4.is_err));
                check("rx4_data", 32'(data4), 32'(e4.data));
            end
        end
        if (rst_n && data4 !== prev_d4) check("data4_changes_only_on_rx", 32'(rx4), 32'd1);
        prev_p4 = rx4 | fe4;
        prev_d4 = data4;
    end

    task automatic hold1(input logic v, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rxd1 = v;
        end
    endtask

    task automatic hold4(input logic v, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rxd4 = v;
        end
    endtask

    // At CLKS_PER_BIT=1 the receiver takes its start sample one cycle after
    // detecting the edge, so this transmitter holds the start level two cycles.
    task automatic send1(input logic [7:0] b);
        hold1(1'b0, 2);
        for (int i = 0; i < 8; i++) hold1(b[i], 1);
        hold1(1'b1, 1);
    endtask

    task automatic send4(input logic [7:0] b, input logic stop, input int gap);
        @(posedge clk); #1;
        frame_t0 = cyc;
        rxd4 = 1'b0;
        hold4(1'b0, 3);
        for (int i = 0; i < 8; i++) hold4(b[i], 4);
        hold4(stop, 4);
        hold4(1'b1, gap);
    endtask

    task automatic wait_pulse4(input int p0, input string name);
        for (int k = 0; k < 12 && pulses4 == p0; k++) @(negedge clk);
        check(name, 32'(pulses4 - p0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        int busy_hi;
        logic [7:0] exp_d;

        vecs[0] = '{8'hA3, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b1};
        vecs[5] = '{8'h7E, 1'b1, 1'b0};
        vecs[6] = '{8'hC5, 1'b1, 1'b0};

        rst_n = 1'b0;
        rxd1  = 1'b1;
        rxd4  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data4", 32'(data4), 32'h00);
        check("reset_busy4", 32'(busy4), 32'd0);
        check("reset_rx4", 32'(rx4 | fe4), 32'd0);
        check("reset_data1", 32'(data1), 32'h00);
        check("reset_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Loopback at CLKS_PER_BIT=1, frames with no idle gap.
        for (int i = 0; i < 4; i++) begin
            q1.push_back('{1'b0, 8'h41 + 8'(i)});
            send1(8'h41 + 8'(i));
        end
        hold1(1'b1, 20);
        check("loop_pulse_count", 32'(pulses1), 32'd4);
        check("loop_queue_empty", 32'(q1.size()), 32'd0);

        // Single 0x55 frame: latency from start edge and busy afterwards.
        p0 = pulses4;
        q4.push_back('{1'b0, 8'h55});
        good4 = 8'h55;
        send4(8'h55, 1'b1, 0);
        wait_pulse4(p0, "f55_pulse");
        check("f55_latency", 32'(last_pulse4 - frame_t0), 32'd41);
        @(negedge clk);
        check("f55_busy_after", 32'(busy4), 32'd0);

        // Table of frames, good and bad stop bits.
        for (int i = 0; i < 7; i++) begin
            exp_d = vecs[i].exp_err ? good4 : vecs[i].byte_v;
            q4.push_back('{vecs[i].exp_err, exp_d});
            if (!vecs[i].exp_err) good4 = vecs[i].byte_v;
            p0 = pulses4;
            send4(vecs[i].byte_v, vecs[i].stop, 4);
            wait_pulse4(p0, $sformatf("vec%0d_pulse", i));
        end

        // One-cycle low glitch on an idle line.
        p0 = pulses4;
        busy_hi = 0;
        hold4(1'b0, 1);
        hold4(1'b1, 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy4) busy_hi++;
        end
        check("glitch_busy_cycles", 32'(busy_hi), 32'd2);
        check("glitch_busy_end", 32'(busy4), 32'd0);
        check("glitch_no_pulse", 32'(pulses4 - p0), 32'd0);

        // Reset during data bit 4 of 0xFF.
        p0 = pulses4;
        @(posedge clk); #1;
        rxd4 = 1'b0;
        hold4(1'b0, 3);
        hold4(1'b1, 18);
        check("midframe_busy", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_data", 32'(data4), 32'h00);
        check("midreset_busy", 32'(busy4), 32'd0);
        check("midreset_pulses", 32'(rx4 | fe4), 32'd0);
        good4 = 8'h00;
        hold4(1'b1, 2);
        rst_n = 1'b1;
        hold4(1'b1, 30);
        check("midreset_no_pulse", 32'(pulses4 - p0), 32'd0);
        check("midreset_idle", 32'(busy4), 32'd0);
        q4.push_back('{1'b0, 8'h12});
        good4 = 8'h12;
        send4(8'h12, 1'b1, 4);
        wait_pulse4(p0, "after_reset_pulse");

        // Break: line low for 30 bit times.
        p0 = pulses4;
        q4.push_back('{1'b1, good4});
        hold4(1'b0, 120);
        check("break_one_error", 32'(pulses4 - p0), 32'd1);
        check("break_busy_held", 32'(busy4), 32'd1);
        hold4(1'b1, 6);
        check("break_idle_after", 32'(busy4), 32'd0);
        p0 = pulses4;
        q4.push_back('{1'b0, 8'h99});
        good4 = 8'h99;
        send4(8'h99, 1'b1, 4);
        wait_pulse4(p0, "after_break_pulse");

        repeat (10) @(posedge clk);
        check("q4_empty", 32'(q4.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
